ice_bus_slave_port: RTL and testbench
=====================================

ICE_BUS_SLAVE_PORT -- requirements
Module: ice_bus_slave_port

Interface
REQ-001 Parameter: ADDR, 8'h01, bus address this port answers to.
REQ-002 Parameter: RX_AW, 4, log2 RX FIFO depth (16 bytes).
REQ-003 Parameter: TX_AW, 4, log2 TX FIFO depth (16 bytes).
REQ-004 Ports SHALL be (name dir width meaning); one clock; reset is asynchronous and active-low:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ma_addr  in  8  frame address from bus controller
- ma_data  in  8  master byte
- ma_data_valid  in  1  ma_data beat valid
- ma_frame_valid  in  1  frame in progress
- sl_overflow  out  1  RX overflow flag to controller
- sl_data  out  8  response byte to controller
- sl_arb_request  out  1  arbitration request
- sl_arb_grant  in  1  arbitration grant
- sl_data_latch  in  1  controller consumed sl_data this cycle
- rx_data  out  8  local RX byte (FIFO head)
- rx_first  out  1  head byte is first accepted byte of its frame (event ID)
- rx_valid  out  1  RX FIFO non-empty
- rx_ready  in  1  local side pops head
- tx_data  in  8  local response byte
- tx_valid  in  1  tx_data write strobe
- tx_commit  in  1  closes current response packet
- tx_ready  out  1  TX FIFO not full

Function
REQ-005 Accepted beat: ma_frame_valid & ma_data_valid & (ma_addr == ADDR); all other beats ignored.
REQ-006 Accepted beat SHALL push {first, ma_data} into RX FIFO; first=1 for first accepted beat after ma_frame_valid was low, else 0.
REQ-007 Full/empty SHALL derive from registered occupancy count (width RX_AW+1); push when full is dropped even if a pop occurs same cycle.
REQ-008 Pop on rx_valid & rx_ready; pop when empty ignored; simultaneous push and pop (not full) keeps count unchanged.
REQ-009 rx_data/rx_first SHALL be combinational FIFO head; 0 when empty.
REQ-010 Accepted beat while RX full SHALL set sl_overflow (registered, visible next cycle); all further beats of that frame dropped.
REQ-011 sl_overflow SHALL clear on first cycle ma_frame_valid is sampled low.
REQ-012 TX write on tx_valid & tx_ready; tx_ready = ~TX full (registered count width TX_AW+1); write when full dropped.
REQ-013 Committed byte counter C (width TX_AW+1): tx_commit SHALL add all uncommitted bytes, including a byte written the same cycle.
REQ-014 tx_commit with zero uncommitted bytes SHALL be a no-op.
REQ-015 TX FSM states: TX_IDLE, TX_REQ, TX_SEND.
REQ-016 TX_IDLE -> TX_REQ when C != 0; sl_arb_request SHALL be registered, high in TX_REQ and TX_SEND only.
REQ-017 TX_REQ -> TX_SEND when sl_arb_grant sampled high.
REQ-018 In TX_SEND, sl_data SHALL be combinational TX head; pop and C decrement on sl_data_latch.
REQ-019 Latch of last committed byte (C==1) -> TX_IDLE; request deasserts next cycle; uncommitted bytes never sent.
REQ-020 sl_data SHALL be 8'h00 outside TX_SEND; sl_data_latch outside TX_SEND or with C==0 ignored.
REQ-021 Grant dropping in TX_SEND before C==0 SHALL return to TX_REQ, keeping request asserted.
REQ-022 Local write and bus pop in same cycle SHALL both take effect; count unchanged.

Reset
REQ-023 rst_n low SHALL asynchronously clear both FIFOs, occupancy counts, C, uncommitted count, first-tracking, and FSM to TX_IDLE.
REQ-024 Reset outputs: sl_overflow=0, sl_arb_request=0, sl_data=0, rx_valid=0, rx_data=0, rx_first=0, tx_ready=1.
REQ-025 Reset mid-frame or mid-send SHALL discard all buffered data; no partial packet resumes after release.

Verification
REQ-026 Frame addr 8'h01, bytes 8'hA5,8'h03,8'h10,8'h11,8'h12 -> RX yields same 5 bytes in order, rx_first=1 only on 8'hA5.
REQ-027 Frame to addr 8'h02 -> RX FIFO stays empty, sl_overflow=0.
REQ-028 rx_ready=0, 17-byte frame to 8'h01 -> 16 bytes stored, sl_overflow=1 cycle after 17th beat, clears after ma_frame_valid falls.
REQ-029 Write 8'h55,8'hAA with tx_commit on second -> request next cycle; grant held, latch each cycle -> sl_data 8'h55 then 8'hAA; request low after.
REQ-030 Write 3 bytes, no commit -> sl_arb_request stays 0 for 100 cycles; commit then -> all 3 sent.
REQ-031 rst_n low during TX_SEND after 1 of 4 bytes -> immediate sl_arb_request=0, tx_ready=1, C=0.

Source files
------------

// File: rtl/ice_bus_slave_port.sv
// ice_bus_slave_port: slave endpoint on the ICE bus.
// RX path: bytes addressed to ADDR are queued with a first-of-frame tag for
// the local side; a frame that hits a full queue raises sl_overflow and the
// rest of that frame is dropped.
// TX path: the local side writes response bytes and commits them as packets;
// committed bytes are offered to the controller through an arbitration
// request/grant handshake and popped on each sl_data_latch.
module ice_bus_slave_port #(
   parameter logic [7:0] ADDR  = 8'h01,
   parameter int         RX_AW = 4,
   parameter int         TX_AW = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] ma_addr,
   input  logic [7:0] ma_data,
   input  logic       ma_data_valid,
   input  logic       ma_frame_valid,
   output logic       sl_overflow,
   output logic [7:0] sl_data,
   output logic       sl_arb_request,
   input  logic       sl_arb_grant,
   input  logic       sl_data_latch,
   output logic [7:0] rx_data,
   output logic       rx_first,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_commit,
   output logic       tx_ready
);

   localparam int             RX_D    = 1 << RX_AW;
   localparam int             TX_D    = 1 << TX_AW;
   localparam logic [RX_AW:0] RX_FULL = (RX_AW+1)'(RX_D);
   localparam logic [TX_AW:0] TX_FULL = (TX_AW+1)'(TX_D);
   localparam logic [TX_AW:0] TX_ONE  = (TX_AW+1)'(1);

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_REQ  = 2'd1,
      TX_SEND = 2'd2
   } tx_state_t;

   // ---------------------------------------------------------------- RX side
   logic [8:0]       r_rx_mem [RX_D];
   logic [RX_AW-1:0] r_rx_wp;
   logic [RX_AW-1:0] r_rx_rp;
   logic [RX_AW:0]   r_rx_cnt;
   logic             r_in_frame;   // an accepted beat has been seen in this frame
   logic             r_ovf;

   logic             w_acc;
   logic             w_rx_full;
   logic             w_rx_empty;
   logic             w_rx_push;
   logic             w_rx_pop;
   logic [8:0]       w_rx_head;

   assign w_acc      = ma_frame_valid & ma_data_valid & (ma_addr == ADDR);
   assign w_rx_full  = (r_rx_cnt == RX_FULL);
   assign w_rx_empty = (r_rx_cnt == '0);
   // Full is judged on the registered count, so a same-cycle pop never makes
   // room for a push; once overflowed, the rest of the frame is discarded.
   assign w_rx_push  = w_acc & ~w_rx_full & ~r_ovf;
   assign w_rx_pop   = ~w_rx_empty & rx_ready;
   assign w_rx_head  = r_rx_mem[r_rx_rp];

   // RX storage: entry is {first, byte}; contents are qualified by the count
   always_ff @(posedge clk) begin
      if (w_rx_push) begin
         r_rx_mem[r_rx_wp] <= {~r_in_frame, ma_data};
      end
   end

   // RX pointers, occupancy, first-of-frame tracking and overflow flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_wp    <= '0;
         r_rx_rp    <= '0;
         r_rx_cnt   <= '0;
         r_in_frame <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         if (w_rx_push) begin
            r_rx_wp <= r_rx_wp + RX_AW'(1);
         end
         if (w_rx_pop) begin
            r_rx_rp <= r_rx_rp + RX_AW'(1);
         end
         case ({w_rx_push, w_rx_pop})
            2'b10:   r_rx_cnt <= r_rx_cnt + (RX_AW+1)'(1);
            2'b01:   r_rx_cnt <= r_rx_cnt - (RX_AW+1)'(1);
            default: r_rx_cnt <= r_rx_cnt;
         endcase
         if (!ma_frame_valid) begin
            r_in_frame <= 1'b0;
            r_ovf      <= 1'b0;
         end else if (w_acc) begin
            r_in_frame <= 1'b1;
            if (w_rx_full) begin
               r_ovf <= 1'b1;
            end
         end
      end
   end

   assign sl_overflow = r_ovf;
   assign rx_valid    = ~w_rx_empty;
   assign rx_data     = w_rx_empty ? 8'h00 : w_rx_head[7:0];
   assign rx_first    = w_rx_empty ? 1'b0  : w_rx_head[8];

   // ---------------------------------------------------------------- TX side
   logic [7:0]       r_tx_mem [TX_D];
   logic [TX_AW-1:0] r_tx_wp;
   logic [TX_AW-1:0] r_tx_rp;
   logic [TX_AW:0]   r_tx_cnt;
   logic [TX_AW:0]   r_c;          // committed bytes not yet latched by the bus
   logic [TX_AW:0]   r_unc;        // written bytes awaiting a commit
   logic             r_req;
   tx_state_t        r_state;
   tx_state_t        w_nstate;

   logic             w_tx_full;
   logic             w_tx_wr;
   logic             w_tx_pop;
   logic             w_send;
   logic [TX_AW:0]   w_c_nxt;
   logic [TX_AW:0]   w_unc_nxt;

   assign w_tx_full = (r_tx_cnt == TX_FULL);
   assign w_tx_wr   = tx_valid & ~w_tx_full;
   assign w_send    = (r_state == TX_SEND);
   assign w_tx_pop  = w_send & sl_data_latch & (r_c != '0);

   // Commit folds in every uncommitted byte, including one written this cycle
   always_comb begin
      w_c_nxt   = r_c - (TX_AW+1)'(w_tx_pop);
      w_unc_nxt = r_unc + (TX_AW+1)'(w_tx_wr);
      if (tx_commit) begin
         w_c_nxt   = w_c_nxt + w_unc_nxt;
         w_unc_nxt = '0;
      end
   end

   // TX storage: write-only port on the local side
   always_ff @(posedge clk) begin
      if (w_tx_wr) begin
         r_tx_mem[r_tx_wp] <= tx_data;
      end
   end

   // TX pointers, occupancy and committed/uncommitted byte counts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_wp  <= '0;
         r_tx_rp  <= '0;
         r_tx_cnt <= '0;
         r_c      <= '0;
         r_unc    <= '0;
      end else begin
         if (w_tx_wr) begin
            r_tx_wp <= r_tx_wp + TX_AW'(1);
         end
         if (w_tx_pop) begin
            r_tx_rp <= r_tx_rp + TX_AW'(1);
         end
         case ({w_tx_wr, w_tx_pop})
            2'b10:   r_tx_cnt <= r_tx_cnt + (TX_AW+1)'(1);
            2'b01:   r_tx_cnt <= r_tx_cnt - (TX_AW+1)'(1);
            default: r_tx_cnt <= r_tx_cnt;
         endcase
         r_c   <= w_c_nxt;
         r_unc <= w_unc_nxt;
      end
   end

   // TX state register; request is registered from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= TX_IDLE;
         r_req   <= 1'b0;
      end else begin
         r_state <= w_nstate;
         r_req   <= (w_nstate != TX_IDLE);
      end
   end

   // TX next state: request once anything is committed, send while granted
   always_comb begin
      w_nstate = r_state;
      case (r_state)
         TX_IDLE: begin
            if (w_c_nxt != '0) begin
               w_nstate = TX_REQ;
            end
         end
         TX_REQ: begin
            if (sl_arb_grant) begin
               w_nstate = TX_SEND;
            end
         end
         TX_SEND: begin
            if (w_tx_pop && (r_c == TX_ONE)) begin
               w_nstate = TX_IDLE;
            end else if (!sl_arb_grant) begin
               w_nstate = TX_REQ;
            end
         end
         default: w_nstate = TX_IDLE;
      endcase
   end

   assign sl_arb_request = r_req;
   assign sl_data        = w_send ? r_tx_mem[r_tx_rp] : 8'h00;
   assign tx_ready       = ~w_tx_full;

endmodule

// File: tb/tb_ice_bus_slave_port.sv
// Self-checking bench for ice_bus_slave_port: directed vector table for the
// RX path, hand sequences for overflow / TX handshake / reset, and random
// traffic checked against queue-based reference models.
module tb_ice_bus_slave_port;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] ma_addr, ma_data;
   logic       ma_data_valid, ma_frame_valid;
   logic       sl_overflow;
   logic [7:0] sl_data;
   logic       sl_arb_request, sl_arb_grant, sl_data_latch;
   logic [7:0] rx_data;
   logic       rx_first, rx_valid, rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid, tx_commit, tx_ready;

   int n_chk  = 0;
   int n_fail = 0;

   // models
   logic [8:0] rq[$];
   logic [7:0] cq[$];
   logic [7:0] uq[$];

   always #5 clk = ~clk;

   ice_bus_slave_port #(.ADDR(8'h01), .RX_AW(4), .TX_AW(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .ma_addr(ma_addr), .ma_data(ma_data),
      .ma_data_valid(ma_data_valid), .ma_frame_valid(ma_frame_valid),
      .sl_overflow(sl_overflow), .sl_data(sl_data),
      .sl_arb_request(sl_arb_request), .sl_arb_grant(sl_arb_grant),
      .sl_data_latch(sl_data_latch),
      .rx_data(rx_data), .rx_first(rx_first), .rx_valid(rx_valid),
      .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_commit(tx_commit),
      .tx_ready(tx_ready)
   );

   typedef struct {
      logic       fv, dv;
      logic [7:0] addr, data;
      logic       rdy;
      logic       ev;
      logic [7:0] ed;
      logic       ef, eo;
   } vec_t;

   vec_t tbl[17];

   function automatic vec_t mk(logic fv, logic dv, logic [7:0] a, logic [7:0] d,
                               logic rdy, logic ev, logic [7:0] ed, logic ef, logic eo);
      vec_t v;
      v.fv = fv; v.dv = dv; v.addr = a; v.data = d; v.rdy = rdy;
      v.ev = ev; v.ed = ed; v.ef = ef; v.eo = eo;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_in();
      ma_addr = 8'h00; ma_data = 8'h00; ma_data_valid = 1'b0; ma_frame_valid = 1'b0;
      sl_arb_grant = 1'b0; sl_data_latch = 1'b0; rx_ready = 1'b0;
      tx_data = 8'h00; tx_valid = 1'b0; tx_commit = 1'b0;
   endtask

   // local write of one byte, optionally committing; model tracks acceptance
   task automatic tx_write(input logic [7:0] d, input bit commit);
      chk("tx_ready", tx_ready, (cq.size() + uq.size()) < 16);
      tx_data = d; tx_valid = 1'b1; tx_commit = commit;
      tick();
      if ((cq.size() + uq.size()) < 16) uq.push_back(d);
      if (commit) begin
         foreach (uq[k]) cq.push_back(uq[k]);
         uq.delete();
      end
      tx_valid = 1'b0; tx_commit = 1'b0;
   endtask

   // act as the bus controller: grant, then latch committed bytes until done
   task automatic drain(input bit rnd_latch, input bit rnd_wr);
      int w;
      bit lat, wr;
      logic [7:0] d;
      sl_arb_grant = 1'b1;
      w = 0;
      while (!sl_arb_request && w < 20) begin
         tick();
         w++;
      end
      chk("req_rise", sl_arb_request, 1'b1);
      chk("sl_data_in_req", sl_data, 8'h00);
      tick();  // grant sampled in TX_REQ, now sending
      w = 0;
      while (cq.size() > 0 && w < 300) begin
         lat = rnd_latch ? ($urandom_range(0, 2) != 0) : 1'b1;
         wr  = rnd_wr && ($urandom_range(0, 3) == 0);
         d   = 8'($urandom);
         chk("sl_data", sl_data, cq[0]);
         chk("req_held", sl_arb_request, 1'b1);
         sl_data_latch = lat;
         if (wr) begin
            chk("tx_ready_drain", tx_ready, (cq.size() + uq.size()) < 16);
            tx_valid = 1'b1; tx_data = d;
         end
         tick();
         if (wr && (cq.size() + uq.size()) < 16) uq.push_back(d);
         if (lat) void'(cq.pop_front());
         sl_data_latch = 1'b0; tx_valid = 1'b0;
         w++;
      end
      chk("drain_done", cq.size(), 0);
      chk("req_fall", sl_arb_request, 1'b0);
      chk("sl_data_idle", sl_data, 8'h00);
      sl_arb_grant = 1'b0;
   endtask

   // randomized RX traffic against a frame/queue model
   task automatic rx_random(input int ncyc);
      bit m_ovf = 0, m_inf = 0;
      bit acc, pop, full, push;
      logic [8:0] ent;
      for (int c = 0; c < ncyc; c++) begin
         if ($urandom_range(0, 9) == 0) ma_frame_valid = ~ma_frame_valid;
         ma_data_valid = $urandom_range(0, 3) != 0;
         case ($urandom_range(0, 4))
            0: ma_addr = 8'h02;
            1: ma_addr = 8'h00;
            default: ma_addr = 8'h01;
         endcase
         ma_data  = 8'($urandom);
         rx_ready = (c < ncyc / 2) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 1);
         acc  = ma_frame_valid && ma_data_valid && ma_addr == 8'h01;
         pop  = rq.size() > 0 && rx_ready;
         full = rq.size() == 16;
         push = 0;
         ent  = '0;
         if (!ma_frame_valid) begin
            m_ovf = 0; m_inf = 0;
         end else if (acc) begin
            ent = {~m_inf, ma_data};
            m_inf = 1;
            if (m_ovf || full) m_ovf = 1;
            else push = 1;
         end
         tick();
         if (pop) void'(rq.pop_front());
         if (push) rq.push_back(ent);
         chk("rnd_rx_valid", rx_valid, rq.size() > 0);
         chk("rnd_rx_data", rx_data, rq.size() > 0 ? rq[0][7:0] : 8'h00);
         chk("rnd_rx_first", rx_first, rq.size() > 0 ? rq[0][8] : 1'b0);
         chk("rnd_ovf", sl_overflow, m_ovf);
      end
      idle_in();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      idle_in();
      rst_n = 1'b0;
      tick(); tick();
      // reset state
      chk("rst_ovf", sl_overflow, 1'b0);
      chk("rst_req", sl_arb_request, 1'b0);
      chk("rst_sl_data", sl_data, 8'h00);
      chk("rst_rx_valid", rx_valid, 1'b0);
      chk("rst_rx_data", rx_data, 8'h00);
      chk("rst_rx_first", rx_first, 1'b0);
      chk("rst_tx_ready", tx_ready, 1'b1);
      rst_n = 1'b1;
      tick();

      // directed RX vectors: {fv,dv,addr,data,rdy} -> {valid,data,first,ovf} after the edge
      tbl[0]  = mk(1, 1, 8'h01, 8'hA5, 0, 1, 8'hA5, 1, 0);
      tbl[1]  = mk(1, 1, 8'h01, 8'h03, 0, 1, 8'hA5, 1, 0);
      tbl[2]  = mk(1, 1, 8'h01, 8'h10, 0, 1, 8'hA5, 1, 0);
      tbl[3]  = mk(1, 0, 8'h01, 8'hEE, 0, 1, 8'hA5, 1, 0);
      tbl[4]  = mk(1, 1, 8'h01, 8'h11, 0, 1, 8'hA5, 1, 0);
      tbl[5]  = mk(1, 1, 8'h01, 8'h12, 0, 1, 8'hA5, 1, 0);
      tbl[6]  = mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h03, 0, 0);
      tbl[7]  = mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 0, 0);
      tbl[8]  = mk(0, 1, 8'h01, 8'h99, 1, 1, 8'h11, 0, 0);
      tbl[9]  = mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h12, 0, 0);
      tbl[10] = mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0);
      tbl[11] = mk(1, 1, 8'h02, 8'h77, 0, 0, 8'h00, 0, 0);
      tbl[12] = mk(1, 1, 8'h02, 8'h78, 0, 0, 8'h00, 0, 0);
      tbl[13] = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0);
      tbl[14] = mk(1, 1, 8'h01, 8'h5A, 1, 1, 8'h5A, 1, 0);
      tbl[15] = mk(1, 1, 8'h01, 8'h6B, 1, 1, 8'h6B, 0, 0);
      tbl[16] = mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0);
      for (int i = 0; i < 17; i++) begin
         ma_frame_valid = tbl[i].fv; ma_data_valid = tbl[i].dv;
         ma_addr = tbl[i].addr; ma_data = tbl[i].data; rx_ready = tbl[i].rdy;
         tick();
         chk($sformatf("vec%0d_valid", i), rx_valid, tbl[i].ev);
         chk($sformatf("vec%0d_data", i), rx_data, tbl[i].ed);
         chk($sformatf("vec%0d_first", i), rx_first, tbl[i].ef);
         chk($sformatf("vec%0d_ovf", i), sl_overflow, tbl[i].eo);
      end
      idle_in();
      tick();

      // overflow: 17-byte frame with nothing popping
      ma_frame_valid = 1'b1; ma_data_valid = 1'b1; ma_addr = 8'h01;
      for (int i = 0; i < 17; i++) begin
         ma_data = 8'(8'h20 + i);
         tick();
         if (i == 15) chk("ovf_before_17th", sl_overflow, 1'b0);
         if (i == 16) chk("ovf_after_17th", sl_overflow, 1'b1);
      end
      chk("ovf_head", rx_data, 8'h20);
      chk("ovf_head_first", rx_first, 1'b1);
      ma_data = 8'hFF; rx_ready = 1'b1;  // room appears, but rest of frame is dropped
      tick();
      chk("ovf_sticky", sl_overflow, 1'b1);
      rx_ready = 1'b0; ma_frame_valid = 1'b0; ma_data_valid = 1'b0;
      tick();
      chk("ovf_clear", sl_overflow, 1'b0);
      rx_ready = 1'b1;
      for (int i = 1; i < 16; i++) begin
         chk("ovf_drain_data", rx_data, 8'(8'h20 + i));
         chk("ovf_drain_first", rx_first, 1'b0);
         tick();
      end
      chk("ovf_drained", rx_valid, 1'b0);
      rx_ready = 1'b0;

      // randomized RX
      rq.delete();
      rx_random(600);
      rx_ready = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      chk("rx_rnd_empty", rx_valid, 1'b0);
      idle_in();
      tick();

      // two-byte packet, latched every cycle
      tx_write(8'h55, 1'b0);
      tx_write(8'hAA, 1'b1);
      chk("req_after_commit", sl_arb_request, 1'b1);
      drain(1'b0, 1'b0);

      // empty commit is a no-op
      tx_commit = 1'b1;
      tick();
      tx_commit = 1'b0;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (sl_arb_request) seen = 1;
      end
      chk("empty_commit_noop", seen, 1'b0);

      // uncommitted bytes never requested; stray latch/grant ignored
      tx_write(8'h01, 1'b0); tx_write(8'h02, 1'b0); tx_write(8'h03, 1'b0);
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         sl_arb_grant = $urandom_range(0, 1); sl_data_latch = $urandom_range(0, 1);
         tick();
         if (sl_arb_request || sl_data != 8'h00) seen = 1;
      end
      sl_arb_grant = 1'b0; sl_data_latch = 1'b0;
      chk("uncommitted_quiet", seen, 1'b0);
      tx_commit = 1'b1;
      tick();
      tx_commit = 1'b0;
      foreach (uq[k]) cq.push_back(uq[k]);
      uq.delete();
      drain(1'b1, 1'b0);

      // TX full: 17th write dropped, commit still covers the 16 stored
      for (int i = 0; i < 17; i++) tx_write(8'(8'hC0 + i), i == 16);
      chk("tx_full_committed", cq.size(), 16);
      drain(1'b1, 1'b0);

      // randomized TX with concurrent local writes during sends
      for (int r = 0; r < 6; r++) begin
         int n = $urandom_range(1, 10);
         for (int i = 0; i < n; i++) tx_write(8'($urandom), $urandom_range(0, 3) == 0);
         if (cq.size() > 0) drain(1'b1, 1'b1);
      end
      tx_commit = 1'b1;
      tick();
      tx_commit = 1'b0;
      foreach (uq[k]) cq.push_back(uq[k]);
      uq.delete();
      if (cq.size() > 0) drain(1'b1, 1'b0);

      // reset in the middle of a send, with RX data buffered too
      ma_frame_valid = 1'b1; ma_data_valid = 1'b1; ma_addr = 8'h01; ma_data = 8'h42;
      tick();
      idle_in();
      chk("pre_rst_rx", rx_valid, 1'b1);
      tx_write(8'hD0, 1'b0); tx_write(8'hD1, 1'b0); tx_write(8'hD2, 1'b0); tx_write(8'hD3, 1'b1);
      sl_arb_grant = 1'b1;
      tick(); tick();
      chk("mid_send_data0", sl_data, 8'hD0);
      sl_data_latch = 1'b1;
      tick();
      chk("mid_send_data1", sl_data, 8'hD1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_req", sl_arb_request, 1'b0);
      chk("rst_mid_tx_ready", tx_ready, 1'b1);
      chk("rst_mid_sl_data", sl_data, 8'h00);
      chk("rst_mid_rx_valid", rx_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      cq.delete(); uq.delete();
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (sl_arb_request || sl_data != 8'h00) seen = 1;
      end
      chk("no_resume_after_rst", seen, 1'b0);
      sl_arb_grant = 1'b0; sl_data_latch = 1'b0;
      tx_write(8'h7E, 1'b1);
      drain(1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
